seg7_scan_ctrl: RTL

- Time-multiplexed scan controller for the board's common-anode 7-segment display.
- Sequences one shared BCD-to-7-segment decoder across NUM_DIGITS digits: drives the current digit's BCD code to the decoder and enables one anode at a time.
- Double-buffers the score/value so a new value never changes the display mid-frame (no tearing).
- Sits between the game score logic and the external decoder/anode pins.

---
 rtl/seg7_scan_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Time-multiplexed scan controller for a common-anode 7-segment display.
// One shared BCD-to-7-segment decoder is time-shared across NUM_DIGITS
// digits. Each digit slot lasts REFRESH_DIV clocks. The slot opens with
// GAP_CYCLES blank clocks, with all anodes off to prevent ghosting. The
// current digit's anode is then enabled. New values are double-buffered
// and only move into the display register on a frame wrap, so a value
// never changes part-way through a frame.
//
// Optional feature (compile-time macro):
//   SEG7_LEADING_ZERO_BLANK_EN - blank zero digits above the most
//   significant non-zero digit. Digit 0 is never blanked.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   digits_in  in   packed BCD value, digit 0 in [3:0] (least significant)
//   load       in   one-cycle strobe capturing digits_in
//   load_ack   out  one-cycle pulse when a captured value becomes displayed
//   bcd_out    out  BCD code of the current digit (decoder input)
//   anode_n    out  active-low anode enables, at most one bit low
//   digit_idx  out  index of the current slot
//   frame_done out  one-cycle pulse when digit_idx wraps to 0
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DIV_W       = 17,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic                          load,
    output logic                          load_ack,
    output logic [3:0]                    bcd_out,
    output logic [NUM_DIGITS-1:0]         anode_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic ST_GAP   = 1'b0;
    localparam logic ST_DRIVE = 1'b1;
    // With no gap configured, the blank phase does not exist, so reset
    // goes straight to the drive phase.
    localparam logic ST_RESET = (GAP_CYCLES == 0) ? ST_DRIVE : ST_GAP;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [DIV_W-1:0]        r_presc;
    logic [GAP_W-1:0]        r_gap_cnt;
    logic                    r_state;
    logic [IDX_W-1:0]        r_digit_idx;
    logic                    r_frame_done;
    logic [4*NUM_DIGITS-1:0] r_display;
    logic [4*NUM_DIGITS-1:0] r_pending;
    logic                    r_pend_valid;
    logic                    r_load_ack;
    logic [3:0]              r_bcd;
    logic [NUM_DIGITS-1:0]   r_anode_n;

    logic                    w_tick;
    logic                    w_wrap;
    logic [3:0]              w_cur_digit;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [NUM_DIGITS-1:0]   w_anode_next;

    assign w_tick      = (r_presc == DIV_LAST);
    assign w_wrap      = w_tick && (r_digit_idx == IDX_LAST);
    assign w_cur_digit = r_display[{r_digit_idx, 2'b00} +: 4];

    // Free-running prescaler. It is independent of the FSM and defines the
    // slot boundaries.
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values, whatever order the always blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + DIV_W'(1);
        end
    end

    // Slot index and frame-wrap pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit_idx  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (w_tick) begin
                r_digit_idx <= w_wrap ? '0 : r_digit_idx + IDX_W'(1);
            end
        end
    end

    // Gap/drive FSM. A tick restarts the blank phase of the new slot,
    // whatever state the FSM is in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RESET;
            r_gap_cnt <= '0;
        end else if (w_tick) begin
            r_state   <= ST_RESET;
            r_gap_cnt <= '0;
        end else if (r_state == ST_GAP) begin
            if (r_gap_cnt == GAP_LAST) begin
                r_state <= ST_DRIVE;
            end else begin
                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end
        end
    end

    // Double buffer. A load on the wrap cycle bypasses the pending register,
    // so the newest value always wins. A later load simply overwrites
    // pending, so only one ack is produced per transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_display    <= '0;
            r_pending    <= '0;
            r_pend_valid <= 1'b0;
            r_load_ack   <= 1'b0;
        end else if (w_wrap && load) begin
            r_display    <= digits_in;
            r_pend_valid <= 1'b0;
            r_load_ack   <= 1'b1;
        end else if (w_wrap && r_pend_valid) begin
            r_display    <= r_pending;
            r_pend_valid <= 1'b0;
            r_load_ack   <= 1'b1;
        end else begin
            r_load_ack <= 1'b0;
            if (load) begin
                r_pending    <= digits_in;
                r_pend_valid <= 1'b1;
            end
        end
    end

    // Blank mask: a non-decimal code is never lit. Optionally, leading zeros
    // are suppressed as well.
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic w_lz_run;
`endif
    // NOTE: every combinational output gets a default before any
    // conditional update, so no path leaves it unassigned (no latch).
    always_comb begin
        w_blank = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_blank[i] = (r_display[4*i +: 4] > 4'd9);
        end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        // Walk down from the top digit while all digits seen so far are zero.
        // The loop stops above digit 0, so a value of zero still shows "0".
        w_lz_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_lz_run = w_lz_run & (r_display[4*i +: 4] == 4'd0);
            if (w_lz_run) begin
                w_blank[i] = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        w_anode_next = '1;
        if ((r_state == ST_DRIVE) && !w_blank[r_digit_idx]) begin
            w_anode_next[r_digit_idx] = 1'b0;
        end
    end

    // Registered pin drivers. The anode lags the FSM state by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_anode_n <= '1;
            r_bcd     <= '0;
        end else begin
            r_anode_n <= w_anode_next;
            r_bcd     <= w_cur_digit;
        end
    end

    assign anode_n    = r_anode_n;
    assign bcd_out    = r_bcd;
    assign digit_idx  = r_digit_idx;
    assign frame_done = r_frame_done;
    assign load_ack   = r_load_ack;

endmodule
